// File: rtl/peripheral_responder_pkg.sv
// Shared register-map constants and types for the memory-mapped peripheral block.
// Offsets are byte offsets inside the 32-byte window.
package peripheral_responder_pkg;

  localparam logic [4:0] TH_OFF      = 5'h00;
  localparam logic [4:0] TL_OFF      = 5'h04;
  localparam logic [4:0] TCON_OFF    = 5'h08;
  localparam logic [4:0] LED_OFF     = 5'h0C;
  localparam logic [4:0] SW_OFF      = 5'h10;
  localparam logic [4:0] DIGI_OFF    = 5'h14;
  localparam logic [4:0] SYSTICK_OFF = 5'h18;

  localparam int TCON_EN  = 0;
  localparam int TCON_IEN = 1;
  localparam int TCON_IRQ = 2;

  typedef enum logic [1:0] {
    TMR_WR_NONE,
    TMR_WR_TH,
    TMR_WR_TL,
    TMR_WR_TCON
  } tmr_wr_sel_e;

  // Word-aligned and not past the last register.
  function automatic logic offset_mapped(input logic [4:0] off);
    return (off[1:0] == 2'b00) && (off <= SYSTICK_OFF);
  endfunction

endpackage

// File: rtl/peripheral_responder_if.sv
// Load/store bus between the MEM stage (master) and the peripheral block (slave).
// Read_data is combinational from the slave within the same cycle.
interface peripheral_responder_if;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Read_data;

  modport master (
    output Address,
    output Write_data,
    output MemRead,
    output MemWrite,
    input  Read_data
  );

  modport slave (
    input  Address,
    input  Write_data,
    input  MemRead,
    input  MemWrite,
    output Read_data
  );
endinterface

// File: rtl/peripheral_responder_reload_timer.sv
// Reloadable 32-bit up-counter: TL counts toward all-ones, reloads from TH on
// overflow and latches a sticky interrupt status in TCON.
module reload_timer
  import peripheral_responder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  tmr_wr_sel_e wr_sel,
  input  logic [31:0] wr_data,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic [2:0]  tcon,
  output logic        irqout
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic        tl_wr;
  logic        ovf;

  assign tl_wr = (wr_sel == TMR_WR_TL);
  assign ovf   = tcon_q[TCON_EN] && !tl_wr && (tl_q == 32'hFFFF_FFFF);

  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;

    if (tcon_q[TCON_EN] && !tl_wr) begin
      tl_d = ovf ? th_q : tl_q + 32'd1;
    end

    case (wr_sel)
      TMR_WR_TH:   th_d   = wr_data;
      TMR_WR_TL:   tl_d   = wr_data;
      TMR_WR_TCON: tcon_d = wr_data[2:0];
      default:     ;
    endcase

    // An overflow in the same cycle as a software clear must not lose the irq.
    if (ovf && tcon_q[TCON_IEN]) begin
      tcon_d[TCON_IRQ] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  assign th     = th_q;
  assign tl     = tl_q;
  assign tcon   = tcon_q;
  assign irqout = tcon_q[TCON_IRQ];

endmodule

// File: rtl/peripheral_responder.sv
// Memory-mapped peripheral slave: address decode, LED/digit/switch registers,
// free-running systick and the reload timer, with same-cycle read data.
module peripheral_responder
  import peripheral_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
  parameter int          LED_WIDTH  = 8,
  parameter int          SW_WIDTH   = 8,
  parameter int          DIGI_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  peripheral_responder_if.slave bus,
  input  logic [SW_WIDTH-1:0]   switch,
  output logic                  irqout,
  output logic [LED_WIDTH-1:0]  led,
  output logic [DIGI_WIDTH-1:0] digi
);

  logic [4:0]            off;
  logic                  hit;
  logic                  wr_hit;
  tmr_wr_sel_e           tmr_wr_sel;
  logic [31:0]           tmr_th, tmr_tl;
  logic [2:0]            tmr_tcon;
  logic [31:0]           rd_val;

  logic [LED_WIDTH-1:0]  led_q, led_d;
  logic [DIGI_WIDTH-1:0] digi_q, digi_d;
  logic [31:0]           systick_q, systick_d;

  assign off    = bus.Address[4:0];
  assign hit    = (bus.Address[31:5] == BASE_ADDR[31:5]) && offset_mapped(off);
  assign wr_hit = bus.MemWrite && hit;

  always_comb begin
    tmr_wr_sel = TMR_WR_NONE;
    led_d      = led_q;
    digi_d     = digi_q;
    systick_d  = systick_q + 32'd1;
    if (wr_hit) begin
      case (off)
        TH_OFF:   tmr_wr_sel = TMR_WR_TH;
        TL_OFF:   tmr_wr_sel = TMR_WR_TL;
        TCON_OFF: tmr_wr_sel = TMR_WR_TCON;
        LED_OFF:  led_d      = bus.Write_data[LED_WIDTH-1:0];
        DIGI_OFF: digi_d     = bus.Write_data[DIGI_WIDTH-1:0];
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q     <= '0;
      digi_q    <= '0;
      systick_q <= '0;
    end else begin
      led_q     <= led_d;
      digi_q    <= digi_d;
      systick_q <= systick_d;
    end
  end

  reload_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .wr_sel  (tmr_wr_sel),
    .wr_data (bus.Write_data),
    .th      (tmr_th),
    .tl      (tmr_tl),
    .tcon    (tmr_tcon),
    .irqout  (irqout)
  );

  // Read path sees pre-write register values, so a simultaneous load/store
  // returns the old contents.
  always_comb begin
    rd_val = 32'h0;
    case (off)
      TH_OFF:      rd_val = tmr_th;
      TL_OFF:      rd_val = tmr_tl;
      TCON_OFF:    rd_val = 32'(tmr_tcon);
      LED_OFF:     rd_val = 32'(led_q);
      SW_OFF:      rd_val = 32'(switch);
      DIGI_OFF:    rd_val = 32'(digi_q);
      SYSTICK_OFF: rd_val = systick_q;
      default:     rd_val = 32'h0;
    endcase
  end

  assign bus.Read_data = (bus.MemRead && hit) ? rd_val : 32'h0;
  assign led           = led_q;
  assign digi          = digi_q;

endmodule

// File: tb/tb_peripheral_responder.sv
// Self-checking bench for peripheral_responder: directed timer/decode sequences,
// a vector table and randomized traffic against a behavioural register model.
module tb_peripheral_responder;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk;
  logic        rst;
  logic [7:0]  sw;
  logic        irqout;
  logic [7:0]  led;
  logic [11:0] digi;

  peripheral_responder_if bus_if ();

  peripheral_responder dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus_if),
    .switch (sw),
    .irqout (irqout),
    .led    (led),
    .digi   (digi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: register contents indexed by word number in the window.
  logic [31:0] m_th, m_tl, m_tick;
  logic [2:0]  m_tcon;
  logic [7:0]  m_led;
  logic [11:0] m_digi;

  function automatic int m_index(input logic [31:0] a);
    longint d;
    d = longint'(a) - longint'(BASE);
    if (d < 0 || d > 24 || (d % 4) != 0) return -1;
    return int'(d / 4);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic rd);
    int idx;
    idx = m_index(a);
    if (!rd || idx < 0) return 32'h0;
    case (idx)
      0: return m_th;
      1: return m_tl;
      2: return {29'h0, m_tcon};
      3: return {24'h0, m_led};
      4: return {24'h0, sw};
      5: return {20'h0, m_digi};
      default: return m_tick;
    endcase
  endfunction

  task automatic m_clock(input logic r, input logic [31:0] a, input logic [31:0] wd,
                         input logic wr);
    int          idx;
    logic        w, wrap;
    logic [31:0] n_tl;
    logic [2:0]  n_tcon;
    if (r) begin
      m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_digi = 0; m_tick = 0;
      return;
    end
    idx    = m_index(a);
    w      = wr && (idx >= 0);
    wrap   = 1'b0;
    n_tl   = m_tl;
    n_tcon = m_tcon;
    if (m_tcon[0] && !(w && idx == 1)) begin
      if (m_tl == 32'hFFFF_FFFF) begin
        n_tl = m_th;
        wrap = m_tcon[1];
      end else begin
        n_tl = m_tl + 1;
      end
    end
    if (w) begin
      case (idx)
        0: m_th   = wd;
        1: n_tl   = wd;
        2: n_tcon = wd[2:0];
        3: m_led  = wd[7:0];
        5: m_digi = wd[11:0];
        default: ;
      endcase
    end
    if (wrap) n_tcon[2] = 1'b1;
    m_tl   = n_tl;
    m_tcon = n_tcon;
    m_tick = m_tick + 1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive, compare same-cycle outputs with the model, clock.
  task automatic step(input logic r, input logic [31:0] a, input logic [31:0] wd,
                      input logic rd, input logic wr, output logic [31:0] got);
    rst                = r;
    bus_if.Address     = a;
    bus_if.Write_data  = wd;
    bus_if.MemRead     = rd;
    bus_if.MemWrite    = wr;
    #4;
    got = bus_if.Read_data;
    check("read_data", got, m_read(a, rd));
    check("irqout", {31'h0, irqout}, {31'h0, m_tcon[2]});
    check("led_digi", {12'h0, led, digi}, {12'h0, m_led, m_digi});
    @(posedge clk);
    m_clock(r, a, wd, wr);
    #1;
  endtask

  task automatic wr_reg(input logic [4:0] off, input logic [31:0] wd);
    logic [31:0] g;
    step(1'b0, BASE + 32'(off), wd, 1'b0, 1'b1, g);
  endtask

  task automatic rd_reg(input logic [4:0] off, output logic [31:0] g);
    step(1'b0, BASE + 32'(off), 32'h0, 1'b1, 1'b0, g);
  endtask

  task automatic idle();
    logic [31:0] g;
    step(1'b0, BASE, 32'h0, 1'b0, 1'b0, g);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
    logic        rd;
    logic        wr;
    logic [7:0]  swv;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [31:0] a, input logic [31:0] wd, input logic rd,
                     input logic wr, input logic [7:0] swv, input logic [31:0] exp);
    vec_t v;
    v.addr = a; v.wd = wd; v.rd = rd; v.wr = wr; v.swv = swv; v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] g, a, wd;
    logic        rd, wr, r;
    int          guard;

    sw = 8'h00;
    rst = 1'b1;
    bus_if.Address = 0; bus_if.Write_data = 0; bus_if.MemRead = 0; bus_if.MemWrite = 0;
    @(posedge clk);
    m_clock(1'b1, 0, 0, 0);
    #1;

    // Reset state, then systick counting from 0.
    step(1'b1, BASE + 32'h08, 32'h0, 1'b1, 1'b0, g);
    check("reset_tcon", g, 32'h0);
    check("reset_outs", {19'h0, irqout, led, digi}, 32'h0);
    rd_reg(5'h18, g);
    check("systick_0", g, 32'h0);
    rd_reg(5'h18, g);
    check("systick_1", g, 32'h1);

    // Overflow with reload and interrupt.
    wr_reg(5'h00, 32'hFFFF_FFFC);
    wr_reg(5'h04, 32'hFFFF_FFFE);
    wr_reg(5'h08, 32'h3);
    idle();
    idle();
    rd_reg(5'h04, g);
    check("tl_reload", g, 32'hFFFF_FFFC);
    rd_reg(5'h08, g);
    check("tcon_irq_set", g, 32'h7);
    check("irqout_set", {31'h0, irqout}, 32'h1);

    // Software clear racing an overflow must not drop the irq.
    guard = 0;
    while (m_tl != 32'hFFFF_FFFF && guard < 16) begin
      idle();
      guard++;
    end
    check("reach_ovf", m_tl, 32'hFFFF_FFFF);
    wr_reg(5'h08, 32'h1);
    rd_reg(5'h08, g);
    check("irq_not_lost", g, 32'h5);
    check("irqout_kept", {31'h0, irqout}, 32'h1);
    wr_reg(5'h08, 32'h1);
    check("irqout_clr", {31'h0, irqout}, 32'h0);
    rd_reg(5'h04, g);
    check("tl_counting_a", g, 32'hFFFF_FFFE);
    rd_reg(5'h04, g);
    check("tl_counting_b", g, 32'hFFFF_FFFF);

    // Simultaneous load/store of TL returns the old value.
    a = m_tl;
    step(1'b0, BASE + 32'h04, 32'h10, 1'b1, 1'b1, g);
    check("rw_old_tl", g, a);
    rd_reg(5'h04, g);
    check("rw_new_tl", g, 32'h10);
    rd_reg(5'h04, g);
    check("rw_tl_inc", g, 32'h11);
    wr_reg(5'h08, 32'h0);

    // Decode and simple-register vectors.
    add(BASE + 32'h0C, 32'h0000_00A5, 0, 1, 8'h00, 32'h0);
    add(BASE + 32'h14, 32'h0000_03F7, 0, 1, 8'h00, 32'h0);
    add(BASE + 32'h10, 32'h0000_1234, 0, 1, 8'h00, 32'h0);
    add(BASE + 32'h1C, 32'h0000_1234, 0, 1, 8'h00, 32'h0);
    add(BASE + 32'h0D, 32'h0000_1234, 0, 1, 8'h00, 32'h0);
    add(BASE + 32'h1C, 32'h0,         1, 0, 8'h00, 32'h0);
    add(BASE + 32'h0D, 32'h0,         1, 0, 8'h00, 32'h0);
    add(BASE + 32'h0C, 32'h0,         1, 0, 8'h00, 32'h0000_00A5);
    add(BASE + 32'h14, 32'h0,         1, 0, 8'h00, 32'h0000_03F7);
    add(BASE + 32'h10, 32'h0,         1, 0, 8'h5A, 32'h0000_005A);
    add(BASE + 32'h0C, 32'h0,         0, 0, 8'h5A, 32'h0);
    add(BASE + 32'h20, 32'h0,         1, 0, 8'h5A, 32'h0);
    add(32'h5000_000C, 32'h0,         1, 0, 8'h5A, 32'h0);
    add(32'h0000_000C, 32'h0000_00FF, 0, 1, 8'h5A, 32'h0);
    add(BASE + 32'h0C, 32'h0,         1, 0, 8'h5A, 32'h0000_00A5);
    add(BASE + 32'h00, 32'h0000_0011, 0, 1, 8'h5A, 32'h0);
    add(BASE + 32'h00, 32'h0,         1, 0, 8'h5A, 32'h0000_0011);
    add(BASE + 32'h08, 32'h0,         1, 0, 8'h5A, 32'h0);
    foreach (vecs[i]) begin
      sw = vecs[i].swv;
      step(1'b0, vecs[i].addr, vecs[i].wd, vecs[i].rd, vecs[i].wr, g);
      check($sformatf("vec%0d", i), g, vecs[i].exp);
    end
    check("led_kept", {24'h0, led}, 32'hA5);
    check("digi_kept", {20'h0, digi}, 32'h3F7);

    // Reset mid-count.
    wr_reg(5'h04, 32'h5);
    wr_reg(5'h08, 32'h3);
    idle();
    step(1'b1, BASE, 32'h0, 1'b0, 1'b0, g);
    rd_reg(5'h04, g);
    check("rst_tl", g, 32'h0);
    rd_reg(5'h08, g);
    check("rst_tcon", g, 32'h0);
    check("rst_irq", {31'h0, irqout}, 32'h0);
    idle();
    idle();
    rd_reg(5'h04, g);
    check("rst_tl_frozen", g, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 9))
        0:       a = BASE + 32'h1C;
        1:       a = BASE + 32'($urandom_range(0, 31));
        2:       a = $urandom;
        default: a = BASE + 32'(4 * $urandom_range(0, 6));
      endcase
      case ($urandom_range(0, 3))
        0:       wd = 32'hFFFF_FFFF - 32'($urandom_range(0, 6));
        1:       wd = 32'($urandom_range(0, 7));
        default: wd = $urandom;
      endcase
      rd = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 2) == 0);
      r  = ($urandom_range(0, 99) == 0);
      sw = 8'($urandom);
      step(r, a, wd, rd, wr, g);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
